// File: rtl/mesh_pkg.sv
// Shared types for the systolic mesh edge logic: element type and feeder FSM states.
package mesh_pkg;

  localparam int unsigned MESH_DATA_WIDTH = 32;

  typedef logic [MESH_DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    DRAIN
  } feeder_state_e;

endpackage

// File: rtl/mesh_skew_feeder_if.sv
// Host-to-feeder beat channel: one north vector and one west vector per accepted beat.
interface mesh_skew_feeder_if #(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    beat_valid;
  logic                    beat_ready;
  logic                    beat_last;
  logic [N*DATA_WIDTH-1:0] beat_north;
  logic [N*DATA_WIDTH-1:0] beat_west;

  modport master (
    output beat_valid,
    output beat_last,
    output beat_north,
    output beat_west,
    input  beat_ready
  );

  modport slave (
    input  beat_valid,
    input  beat_last,
    input  beat_north,
    input  beat_west,
    output beat_ready
  );

endinterface

// File: rtl/skew_delay_line.sv
// Fixed-length shift register used to skew one mesh lane; STAGES=0 degenerates to a wire.
module skew_delay_line #(
  parameter int unsigned STAGES     = 1,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  if (STAGES == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign dout_o         = din_i;
  end else begin : g_pipe
    logic [STAGES*DATA_WIDTH-1:0] pipe_q;

    if (STAGES == 1) begin : g_one
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= din_i;
        end
      end
    end else begin : g_many
      // Newest element sits in the low slice, oldest in the high slice.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= {pipe_q[(STAGES-1)*DATA_WIDTH-1:0], din_i};
        end
      end
    end

    assign dout_o = pipe_q[STAGES*DATA_WIDTH-1 -: DATA_WIDTH];
  end

endmodule

// File: rtl/mesh_skew_feeder.sv
// Buffers one frame of host beats, then replays it gap-free onto the mesh north/west edges
// with lane j delayed by j cycles.
module mesh_skew_feeder
  import mesh_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  mesh_skew_feeder_if.slave          beat,
  output logic [N*DATA_WIDTH-1:0]    north_o,
  output logic [N*DATA_WIDTH-1:0]    west_o,
  output logic                       inputs_valid_o,
  output logic                       last_element_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(DEPTH+1)-1:0] frame_len_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LenW = $clog2(DEPTH+1);
  localparam int unsigned CntW = $clog2(N+1);
  localparam int unsigned VecW = N * DATA_WIDTH;

  feeder_state_e   state_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [LenW-1:0] frame_len_q;
  logic [CntW-1:0] drain_cnt_q;
  logic [VecW-1:0] lane0_north_q;
  logic [VecW-1:0] lane0_west_q;
  logic            valid_q;
  logic            last_q;
  logic            done_q;
  logic            accept;

  logic [VecW-1:0] buf_north_q [DEPTH];
  logic [VecW-1:0] buf_west_q  [DEPTH];

  assign beat.beat_ready = (state_q == LOAD);
  assign accept          = beat.beat_valid & beat.beat_ready;

  // Frame storage is deliberately not reset; reads never go past the latched frame length.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      buf_north_q[wr_ptr_q] <= beat.beat_north;
      buf_west_q[wr_ptr_q]  <= beat.beat_west;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= LOAD;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_len_q   <= '0;
      drain_cnt_q   <= '0;
      lane0_north_q <= '0;
      lane0_west_q  <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      lane0_north_q <= '0;
      lane0_west_q  <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      done_q        <= 1'b0;
      unique case (state_q)
        LOAD: begin
          if (accept) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (beat.beat_last || (wr_ptr_q == PtrW'(DEPTH - 1))) begin
              state_q     <= STREAM;
              frame_len_q <= LenW'(wr_ptr_q) + 1'b1;
              rd_ptr_q    <= '0;
            end
          end
        end
        STREAM: begin
          lane0_north_q <= buf_north_q[rd_ptr_q];
          lane0_west_q  <= buf_west_q[rd_ptr_q];
          valid_q       <= 1'b1;
          if ((LenW'(rd_ptr_q) + 1'b1) == frame_len_q) begin
            last_q      <= 1'b1;
            state_q     <= DRAIN;
            drain_cnt_q <= '0;
          end else begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
        end
        DRAIN: begin
          // done_q marks the cycle after lane N-1 shows the final beat; leave on that edge.
          if (done_q) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
            if (drain_cnt_q == CntW'(N - 1)) begin
              done_q <= 1'b1;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    skew_delay_line #(
      .STAGES     (j),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_north (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .din_i  (lane0_north_q[j*DATA_WIDTH +: DATA_WIDTH]),
      .dout_o (north_o[j*DATA_WIDTH +: DATA_WIDTH])
    );

    skew_delay_line #(
      .STAGES     (j),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_west (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .din_i  (lane0_west_q[j*DATA_WIDTH +: DATA_WIDTH]),
      .dout_o (west_o[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign inputs_valid_o = valid_q;
  assign last_element_o = last_q;
  assign done_o         = done_q;
  assign busy_o         = (state_q != LOAD);
  assign frame_len_o    = frame_len_q;

endmodule

// File: tb/tb_mesh_skew_feeder.sv
// Directed bench for mesh_skew_feeder: loads frames, then checks every output cycle by cycle
// against the skew timing measured from the accepting edge of each frame's last beat.
module tb_mesh_skew_feeder;
  import mesh_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;

  typedef logic [N*DW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mesh_skew_feeder_if #(.N(N), .DATA_WIDTH(DW)) bus ();

  vec_t       north;
  vec_t       west;
  logic       iv;
  logic       le;
  logic       busy;
  logic       done;
  logic [3:0] flen;

  mesh_skew_feeder #(
    .N          (N),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .beat           (bus),
    .north_o        (north),
    .west_o         (west),
    .inputs_valid_o (iv),
    .last_element_o (le),
    .busy_o         (busy),
    .done_o         (done),
    .frame_len_o    (flen)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t exp_n [DEPTH];
  vec_t exp_w [DEPTH];

  task automatic check_eq(input string tag, input vec_t got, input vec_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_frame(input int k_len, input int nbase, input int nstride,
                           input int wbase, input int wstride);
    for (int k = 0; k < DEPTH; k++) begin
      exp_n[k] = '0;
      exp_w[k] = '0;
    end
    for (int k = 0; k < k_len; k++) begin
      for (int c = 0; c < N; c++) begin
        exp_n[k][c*DW +: DW] = DW'(nbase + nstride * k + c);
        exp_w[k][c*DW +: DW] = DW'(wbase + wstride * k + c);
      end
    end
  endtask

  // Called and returns at a falling edge; returns in the cycle after the accepting edge.
  task automatic send_beat(input vec_t n, input vec_t w, input logic last);
    bus.beat_valid = 1'b1;
    bus.beat_last  = last;
    bus.beat_north = n;
    bus.beat_west  = w;
    for (int t = 0; t < 100 && !bus.beat_ready; t++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("beat_ready before accept", vec_t'(bus.beat_ready), vec_t'(1'b1));
    @(posedge clk);
    @(negedge clk);
    bus.beat_valid = 1'b0;
    bus.beat_last  = 1'b0;
  endtask

  task automatic load_frame(input int k_len, input logic use_last, input logic gaps);
    for (int k = 0; k < k_len; k++) begin
      send_beat(exp_n[k], exp_w[k], use_last && (k == k_len - 1));
      if (gaps && (k != k_len - 1)) begin
        // Idle cycle with junk on the data fields; must be ignored.
        bus.beat_north = {N{32'hBAD0_BAD0}};
        bus.beat_west  = {N{32'hBAD1_BAD1}};
        bus.beat_last  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.beat_last  = 1'b0;
      end
    end
  endtask

  // Starts at the falling edge of cycle A+1 and checks cycles A+1 .. A+mmax.
  task automatic check_frame(input string name, input int k_len, input int mmax);
    for (int m = 1; m <= mmax; m++) begin
      vec_t en;
      vec_t ew;
      logic bz;
      en = '0;
      ew = '0;
      for (int j = 0; j < N; j++) begin
        int k;
        k = m - 2 - j;
        if (k >= 0 && k < k_len) begin
          en[j*DW +: DW] = exp_n[k][j*DW +: DW];
          ew[j*DW +: DW] = exp_w[k][j*DW +: DW];
        end
      end
      bz = (m <= k_len + 1 + N);
      check_eq($sformatf("%s c%0d north", name, m), north, en);
      check_eq($sformatf("%s c%0d west", name, m), west, ew);
      check_eq($sformatf("%s c%0d inputs_valid", name, m), vec_t'(iv),
               vec_t'(m >= 2 && m <= k_len + 1));
      check_eq($sformatf("%s c%0d last_element", name, m), vec_t'(le), vec_t'(m == k_len + 1));
      check_eq($sformatf("%s c%0d done", name, m), vec_t'(done), vec_t'(m == k_len + 1 + N));
      check_eq($sformatf("%s c%0d busy", name, m), vec_t'(busy), vec_t'(bz));
      check_eq($sformatf("%s c%0d beat_ready", name, m), vec_t'(bus.beat_ready), vec_t'(!bz));
      check_eq($sformatf("%s c%0d frame_len", name, m), vec_t'(flen), vec_t'(k_len));
      if (m < mmax) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic check_idle(input string name, input int exp_len);
    check_eq({name, " north"}, north, '0);
    check_eq({name, " west"}, west, '0);
    check_eq({name, " inputs_valid"}, vec_t'(iv), '0);
    check_eq({name, " last_element"}, vec_t'(le), '0);
    check_eq({name, " done"}, vec_t'(done), '0);
    check_eq({name, " busy"}, vec_t'(busy), '0);
    check_eq({name, " beat_ready"}, vec_t'(bus.beat_ready), vec_t'(1'b1));
    check_eq({name, " frame_len"}, vec_t'(flen), vec_t'(exp_len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.beat_valid = 1'b0;
    bus.beat_last  = 1'b0;
    bus.beat_north = '0;
    bus.beat_west  = '0;
    repeat (2) @(negedge clk);
    check_idle("reset", 0);
    rst = 1'b0;
    @(negedge clk);

    // Frame K=3: north 0x100*k+c, west 0x200*k+r; lane 3 shows 0x203 at A+7, done at A+8.
    set_frame(3, 0, 'h100, 0, 'h200);
    load_frame(3, 1'b1, 1'b0);
    check_frame("k3", 3, 3 + N + 2);

    // Next frame's first beat is accepted in the cycle right after done.
    set_frame(2, 'h1000, 'h10, 'h2000, 'h10);
    load_frame(2, 1'b1, 1'b0);
    check_frame("b2b", 2, 2 + N + 2);

    // K=1: valid and last coincide at A+2; west lane 3 shows 0xDEAD at A+5.
    exp_n[0] = {N{32'h0000_DEAD}};
    exp_w[0] = {N{32'h0000_DEAD}};
    for (int k = 1; k < DEPTH; k++) begin
      exp_n[k] = '0;
      exp_w[k] = '0;
    end
    load_frame(1, 1'b1, 1'b0);
    check_frame("k1", 1, 1 + N + 2);

    // K=5 with an idle host cycle between beats; replay must still be contiguous.
    set_frame(5, 'h3000, 'h10, 'h3800, 'h10);
    load_frame(5, 1'b1, 1'b1);
    check_frame("gap5", 5, 5 + N + 2);

    // Eight beats without last: the eighth accept forces the stream; a ninth waits.
    set_frame(8, 'h4000, 'h10, 'h5000, 'h10);
    load_frame(8, 1'b0, 1'b0);
    bus.beat_valid = 1'b1;
    bus.beat_last  = 1'b1;
    bus.beat_north = {N{32'h9999_0001}};
    bus.beat_west  = {N{32'h9999_0002}};
    check_frame("full8", 8, 8 + N + 2);
    exp_n[0] = {N{32'h9999_0001}};
    exp_w[0] = {N{32'h9999_0002}};
    for (int k = 1; k < DEPTH; k++) begin
      exp_n[k] = '0;
      exp_w[k] = '0;
    end
    load_frame(1, 1'b1, 1'b0);
    check_frame("ninth", 1, 1 + N + 2);

    // Reset during DRAIN at A+6 of a K=3 frame, then a clean K=2 frame.
    set_frame(3, 'h6000, 'h10, 'h6800, 'h10);
    load_frame(3, 1'b1, 1'b0);
    check_frame("pre_rst", 3, 5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle("mid_rst", 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_frame(2, 'h7000, 'h10, 'h7800, 'h10);
    load_frame(2, 1'b1, 1'b0);
    check_frame("post_rst", 2, 2 + N + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
